fire6_expand3_ofm_writer: RTL and testbench

// Downstream neighbour of the fire6 expand3x3 conv stage. On each sample pulse it captures the
// DSP_NO-wide parallel output vector (one 16-bit value per output channel, one pixel) into a

---
 rtl/fire6_expand3_ofm_writer_if.sv | 28 ++
 rtl/fire6_expand3_ofm_writer.sv | 122 ++++++++++++
 tb/tb_fire6_expand3_ofm_writer.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fire6_expand3_ofm_writer_if.sv
// Handshake and RAM-write bundle between the conv stage, the OFM writer and the concat RAM.
interface fire6_expand3_ofm_writer_if #(
    parameter int unsigned DSP_NO = 256,
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ADDR_W = 17
);
    logic                           layer_start;
    logic                           sample_in;
    logic [DSP_NO-1:0][WIDTH-1:0]   ofm_in;
    logic                           wr_en;
    logic [ADDR_W-1:0]              wr_addr;
    logic [WIDTH-1:0]               wr_data;
    logic                           busy;
    logic                           ram_feedback;
    logic                           overrun;

    // Upstream side: drives pixels, observes the write stream and status
    modport master (
        output layer_start, sample_in, ofm_in,
        input  wr_en, wr_addr, wr_data, busy, ram_feedback, overrun
    );

    // Writer side: consumes pixels, produces the write stream and status
    modport slave (
        input  layer_start, sample_in, ofm_in,
        output wr_en, wr_addr, wr_data, busy, ram_feedback, overrun
    );
endinterface

// File: rtl/fire6_expand3_ofm_writer.sv
// Captures one parallel pixel vector from the fire6 expand3x3 stage into a shadow bank and
// serialises it into the concat RAM, one channel per cycle, channel-major / pixel-minor.
module fire6_expand3_ofm_writer #(
    parameter int unsigned DSP_NO    = 256,
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned WOUT      = 16,
    parameter int unsigned CH_OFFSET = 256,
    parameter int unsigned TOTAL_CH  = 512,
    parameter int unsigned ADDR_W    = $clog2(TOTAL_CH * WOUT * WOUT)
) (
    input  logic                           clk,
    input  logic                           rst,
    fire6_expand3_ofm_writer_if.slave      bus
);
    localparam int unsigned PIX   = WOUT * WOUT;
    localparam int unsigned CH_W  = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;
    localparam int unsigned PIX_W = (PIX > 1) ? $clog2(PIX) : 1;

    typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

    state_t                         state_q;
    logic [CH_W-1:0]                ch_cnt_q;
    logic [PIX_W-1:0]               pix_cnt_q;
    logic [DSP_NO-1:0][WIDTH-1:0]   shadow_q;
    logic                           wr_en_q;
    logic [ADDR_W-1:0]              wr_addr_q;
    logic [WIDTH-1:0]               wr_data_q;
    logic                           busy_q;
    logic                           fb_arm_q;
    logic                           ram_feedback_q;
    logic                           overrun_q;

    logic                           capture_c;
    logic                           issue_c;
    logic [CH_W-1:0]                issue_ch_c;
    logic [WIDTH-1:0]               issue_data_c;
    logic                           last_ch_c;
    logic                           last_pix_c;

    // Channel 0 is written straight from ofm_in on the capture edge so the first write
    // lands one cycle after sample_in; later channels come from the shadow bank.
    always_comb begin
        capture_c    = (state_q == IDLE) && bus.sample_in && !bus.layer_start;
        issue_c      = capture_c || ((state_q == DRAIN) && !bus.layer_start);
        issue_ch_c   = (state_q == IDLE) ? '0 : ch_cnt_q;
        issue_data_c = (state_q == IDLE) ? bus.ofm_in[0] : shadow_q[ch_cnt_q];
        last_ch_c    = (issue_ch_c == CH_W'(DSP_NO - 1));
        last_pix_c   = (pix_cnt_q == PIX_W'(PIX - 1));
    end

    // Shadow bank: holds the pixel while it drains; deliberately not reset
    always_ff @(posedge clk) begin
        if (capture_c) begin
            shadow_q <= bus.ofm_in;
        end
    end

    // Control FSM, counters and registered write port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            ch_cnt_q       <= '0;
            pix_cnt_q      <= '0;
            wr_en_q        <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            busy_q         <= 1'b0;
            fb_arm_q       <= 1'b0;
            ram_feedback_q <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            ram_feedback_q <= 1'b0;
            wr_en_q        <= 1'b0;
            if (bus.layer_start) begin
                state_q   <= IDLE;
                ch_cnt_q  <= '0;
                pix_cnt_q <= '0;
                busy_q    <= 1'b0;
                fb_arm_q  <= 1'b0;
                overrun_q <= 1'b0;
            end else begin
                if (issue_c) begin
                    wr_en_q   <= 1'b1;
                    wr_data_q <= issue_data_c;
                    wr_addr_q <= (ADDR_W'(CH_OFFSET) + ADDR_W'(issue_ch_c)) * ADDR_W'(PIX)
                                 + ADDR_W'(pix_cnt_q);
                    if (last_ch_c) begin
                        ch_cnt_q <= '0;
                        busy_q   <= 1'b0;
                        if (last_pix_c) begin
                            state_q  <= DONE;
                            fb_arm_q <= 1'b1;
                        end else begin
                            state_q   <= IDLE;
                            pix_cnt_q <= pix_cnt_q + PIX_W'(1);
                        end
                    end else begin
                        ch_cnt_q <= issue_ch_c + CH_W'(1);
                        busy_q   <= 1'b1;
                        state_q  <= DRAIN;
                    end
                end
                // A pixel arriving mid-drain is lost; flag it until the next layer
                if ((state_q == DRAIN) && bus.sample_in) begin
                    overrun_q <= 1'b1;
                end
                // One feedback pulse on the first cycle after the final write
                if (state_q == DONE) begin
                    ram_feedback_q <= fb_arm_q;
                    fb_arm_q       <= 1'b0;
                end
            end
        end
    end

    assign bus.wr_en        = wr_en_q;
    assign bus.wr_addr      = wr_addr_q;
    assign bus.wr_data      = wr_data_q;
    assign bus.busy         = busy_q;
    assign bus.ram_feedback = ram_feedback_q;
    assign bus.overrun      = overrun_q;
endmodule

// File: tb/tb_fire6_expand3_ofm_writer.sv
// Bench for the fire6 expand3 OFM writer, run at a reduced geometry so a full layer fits.
module tb_fire6_expand3_ofm_writer;
    localparam int unsigned DSP_NO    = 16;
    localparam int unsigned WIDTH     = 16;
    localparam int unsigned WOUT      = 4;
    localparam int unsigned CH_OFFSET = 16;
    localparam int unsigned TOTAL_CH  = 32;
    localparam int unsigned PIX       = WOUT * WOUT;
    localparam int unsigned ADDR_W    = $clog2(TOTAL_CH * PIX);
    localparam int          D         = int'(DSP_NO);

    logic clk = 1'b0;
    logic rst = 1'b0;

    fire6_expand3_ofm_writer_if #(.DSP_NO(DSP_NO), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    fire6_expand3_ofm_writer #(
        .DSP_NO(DSP_NO), .WIDTH(WIDTH), .WOUT(WOUT),
        .CH_OFFSET(CH_OFFSET), .TOTAL_CH(TOTAL_CH), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit wr; int addr; int data; bit busy; bit ovr; bit fb; bit rz;
    } exp_t;
    typedef struct { int addr; int data; } wr_t;
    typedef struct { int gap; bit exp_ovr; int exp_writes; } row_t;

    exp_t e_tab [int];
    wr_t  exp_wr [int];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   wr_cnt = 0;
    int   fb_cnt = 0;
    logic [WIDTH-1:0] vec [DSP_NO];

    // Reference model state: what the writer should be doing, in layer/pixel terms
    int m_pix, m_free_from, busy_lo, busy_hi, fb_cyc;
    bit m_done, m_ovr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic clear_layer(input int from);
        int k;
        m_pix = 0; m_done = 0; m_ovr = 0; m_free_from = from;
        busy_lo = 0; busy_hi = -1;
        if (fb_cyc >= from) fb_cyc = -1;
        while (exp_wr.last(k) && k >= from) exp_wr.delete(k);
    endtask

    // Advance the model by the inputs of cycle cyc and record expectations for cycle cyc+1
    task automatic model_step();
        int   t = cyc;
        exp_t n;
        if (!rst) begin
            clear_layer(t);
            fb_cyc = -1;
            n = '{0, 0, 0, 0, 0, 0, 1};
            e_tab[t] = n;
        end else if (bus.layer_start) begin
            clear_layer(t + 1);
        end else if (bus.sample_in) begin
            if (t < m_free_from) m_ovr = 1;
            else if (!m_done) begin
                for (int c = 0; c < D; c++)
                    exp_wr[t + 1 + c] = '{(int'(CH_OFFSET) + c) * int'(PIX) + m_pix, int'(vec[c])};
                busy_lo = t + 1; busy_hi = t + D - 1; m_free_from = t + D;
                if (m_pix == int'(PIX) - 1) begin m_done = 1; fb_cyc = t + D + 1; end
                else m_pix++;
            end
        end
        n.wr   = exp_wr.exists(t + 1);
        n.addr = n.wr ? exp_wr[t + 1].addr : 0;
        n.data = n.wr ? exp_wr[t + 1].data : 0;
        n.busy = (t + 1 >= busy_lo) && (t + 1 <= busy_hi);
        n.ovr  = m_ovr;
        n.fb   = (fb_cyc == t + 1);
        n.rz   = !rst;
        e_tab[t + 1] = n;
    endtask

    // Cycle-by-cycle comparison against the model, sampled mid-cycle
    always @(negedge clk) begin
        exp_t x;
        if (e_tab.exists(cyc)) begin
            x = e_tab[cyc];
            chk("wr_en", 32'(bus.wr_en), 32'(x.wr));
            if (x.wr) begin
                chk("wr_addr", 32'(bus.wr_addr), x.addr);
                chk("wr_data", 32'(bus.wr_data), x.data);
            end
            if (x.rz) begin
                chk("rst_addr", 32'(bus.wr_addr), 0);
                chk("rst_data", 32'(bus.wr_data), 0);
            end
            chk("busy", 32'(bus.busy), 32'(x.busy));
            chk("overrun", 32'(bus.overrun), 32'(x.ovr));
            chk("ram_feedback", 32'(bus.ram_feedback), 32'(x.fb));
            if (bus.wr_en === 1'b1) wr_cnt++;
            if (bus.ram_feedback === 1'b1) fb_cnt++;
        end
    end

    task automatic tick(input bit ls, input bit smp);
        bus.layer_start = ls;
        bus.sample_in   = smp;
        for (int c = 0; c < D; c++) bus.ofm_in[c] = vec[c];
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        bus.layer_start = 1'b0;
        bus.sample_in   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0);
    endtask

    task automatic rand_vec();
        for (int c = 0; c < D; c++) vec[c] = WIDTH'($urandom);
    endtask

    initial begin
        row_t rows [5];
        int   w0, f0, k;
        bit   strays;

        rows[0] = '{1,     1, D};
        rows[1] = '{10,    1, D};
        rows[2] = '{D - 1, 1, D};
        rows[3] = '{D,     0, 2 * D};
        rows[4] = '{D + 3, 0, 2 * D};

        bus.layer_start = 1'b0;
        bus.sample_in   = 1'b0;
        bus.ofm_in      = '0;
        for (int c = 0; c < D; c++) vec[c] = '0;
        fb_cyc = -1;
        clear_layer(0);

        // Reset state
        #1;
        chk("reset_wr_en", 32'(bus.wr_en), 0);
        chk("reset_addr", 32'(bus.wr_addr), 0);
        chk("reset_data", 32'(bus.wr_data), 0);
        chk("reset_busy", 32'(bus.busy), 0);
        chk("reset_fb", 32'(bus.ram_feedback), 0);
        chk("reset_overrun", 32'(bus.overrun), 0);
        idle(2);
        rst = 1'b1;
        idle(2);

        // Single pixel, ofm_in[c] = c: first and last write, busy drop, hold after drain
        tick(1, 0);
        for (int c = 0; c < D; c++) vec[c] = WIDTH'(c);
        w0 = wr_cnt;
        tick(0, 1);
        chk("t1_first_en", 32'(bus.wr_en), 1);
        chk("t1_first_addr", 32'(bus.wr_addr), CH_OFFSET * PIX);
        chk("t1_first_data", 32'(bus.wr_data), 0);
        chk("t1_busy_hi", 32'(bus.busy), 1);
        idle(D - 1);
        chk("t1_last_en", 32'(bus.wr_en), 1);
        chk("t1_last_addr", 32'(bus.wr_addr), (CH_OFFSET + DSP_NO - 1) * PIX);
        chk("t1_last_data", 32'(bus.wr_data), DSP_NO - 1);
        chk("t1_busy_drop", 32'(bus.busy), 0);
        idle(1);
        chk("t1_idle_en", 32'(bus.wr_en), 0);
        chk("t1_hold_addr", 32'(bus.wr_addr), (CH_OFFSET + DSP_NO - 1) * PIX);
        chk("t1_hold_data", 32'(bus.wr_data), DSP_NO - 1);
        idle(2);
        chk("t1_write_count", 32'(wr_cnt - w0), D);

        // Two samples at varying spacing: overrun exactly when the second lands mid-drain
        foreach (rows[r]) begin
            tick(1, 0);
            rand_vec();
            w0 = wr_cnt;
            tick(0, 1);
            rand_vec();
            idle(rows[r].gap - 1);
            tick(0, 1);
            idle(2 * D + 2);
            chk("pair_overrun", 32'(bus.overrun), 32'(rows[r].exp_ovr));
            chk("pair_writes", 32'(wr_cnt - w0), rows[r].exp_writes);
            rand_vec();
            tick(0, 1);
            idle(D + 2);
        end

        // Full clean layer with random data and spacing: one feedback pulse, no overrun
        tick(1, 0);
        w0 = wr_cnt; f0 = fb_cnt;
        for (int p = 0; p < int'(PIX); p++) begin
            rand_vec();
            tick(0, 1);
            idle(D - 1 + int'($urandom_range(0, 6)));
        end
        idle(4);
        chk("layer_writes", 32'(wr_cnt - w0), D * int'(PIX));
        chk("layer_fb_count", 32'(fb_cnt - f0), 1);
        chk("layer_overrun", 32'(bus.overrun), 0);

        // Surplus sample after the layer completed is ignored
        w0 = wr_cnt; f0 = fb_cnt;
        tick(0, 1);
        idle(D + 3);
        chk("done_writes", 32'(wr_cnt - w0), 0);
        chk("done_fb", 32'(fb_cnt - f0), 0);
        chk("done_overrun", 32'(bus.overrun), 0);

        // Restart from DONE writes pixel 0 again
        tick(1, 0);
        rand_vec();
        tick(0, 1);
        chk("restart_addr", 32'(bus.wr_addr), CH_OFFSET * PIX);
        idle(D + 2);

        // Layer with random stray pulses landing mid-drain
        tick(1, 0);
        strays = 0;
        w0 = wr_cnt;
        for (int p = 0; p < int'(PIX); p++) begin
            rand_vec();
            tick(0, 1);
            if ($urandom_range(0, 2) == 0) begin
                k = int'($urandom_range(1, D - 1));
                strays = 1;
                idle(k - 1);
                tick(0, 1);
                idle(D - k - 1 + int'($urandom_range(0, 4)));
            end else begin
                idle(D - 1 + int'($urandom_range(0, 4)));
            end
        end
        idle(4);
        chk("stray_overrun", 32'(bus.overrun), 32'(strays));
        chk("stray_writes", 32'(wr_cnt - w0), D * int'(PIX));

        // layer_start coincident with sample_in mid-drain aborts and drops the sample
        tick(1, 0);
        rand_vec();
        w0 = wr_cnt;
        tick(0, 1);
        idle(3);
        tick(1, 1);
        chk("ls_abort_en", 32'(bus.wr_en), 0);
        chk("ls_abort_busy", 32'(bus.busy), 0);
        idle(D + 2);
        chk("ls_abort_writes", 32'(wr_cnt - w0), 4);

        // Asynchronous reset in the middle of a drain
        tick(1, 0);
        rand_vec();
        tick(0, 1);
        idle(4);
        rst = 1'b0;
        #1;
        chk("rst_mid_en", 32'(bus.wr_en), 0);
        chk("rst_mid_busy", 32'(bus.busy), 0);
        idle(2);
        rst = 1'b1;
        tick(1, 0);
        rand_vec();
        w0 = wr_cnt;
        tick(0, 1);
        chk("post_rst_addr", 32'(bus.wr_addr), CH_OFFSET * PIX);
        idle(D + 2);
        chk("post_rst_writes", 32'(wr_cnt - w0), D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
